// File: rtl/cpu_core_pkg.sv
// Shared definitions for the cpu_core multi-cycle load/store processor:
// opcodes, instruction field positions, FSM states and small helpers.
package cpu_core_pkg;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 28;
  localparam int RD_MSB = 27;
  localparam int RD_LSB = 24;
  localparam int RS_MSB = 23;
  localparam int RS_LSB = 20;
  localparam int RT_MSB = 19;
  localparam int RT_LSB = 16;
  localparam int IMM_MSB = 15;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_XOR   = 4'h5;
  localparam logic [3:0] OP_ADDI  = 4'h6;
  localparam logic [3:0] OP_LUI   = 4'h7;
  localparam logic [3:0] OP_LOAD  = 4'h8;
  localparam logic [3:0] OP_STORE = 4'h9;
  localparam logic [3:0] OP_BEQ   = 4'hA;
  localparam logic [3:0] OP_BNE   = 4'hB;
  localparam logic [3:0] OP_JMP   = 4'hC;
  localparam logic [3:0] OP_SLT   = 4'hD;
  localparam logic [3:0] OP_MUL   = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_WREL,
    ST_HALT
  } state_e;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/cpu_core_alu.sv
// Combinational ALU for cpu_core: result, equality and signed less-than.
// MUL is only present when CPU_MUL_EN is defined.
module cpu_core_alu
  import cpu_core_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o,
  output logic        eq_o,
  output logic        lt_o
);

  always_comb begin
    // Address generation for LOAD/STORE and ADDI fall through to the adder
    result_o = a_i + b_i;
    case (op_i)
      OP_SUB: result_o = a_i - b_i;
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_XOR: result_o = a_i ^ b_i;
      OP_LUI: result_o = {b_i[15:0], 16'h0000};
`ifdef CPU_MUL_EN
      OP_MUL: result_o = a_i * b_i;
`endif
      default: result_o = a_i + b_i;
    endcase
  end

  assign eq_o = (a_i == b_i);
  assign lt_o = ($signed(a_i) < $signed(b_i));

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle 32-bit load/store CPU, sole master of the memory bus.
// Optional multiply on opcode E is enabled by defining CPU_MUL_EN.
module cpu_core
  import cpu_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          NREGS    = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        rw,
  output logic [31:0] address_bus,
  input  logic [31:0] data_from_mem,
  output logic [31:0] data_to_mem
);

  state_e      state_q;
  logic [31:0] pc_q, ir_q, addr_q, dout_q;
  logic        rw_q;
  logic        halted;
  logic [31:0] regs_q [NREGS];

  logic [3:0]  op, rd, rs, rt;
  logic [31:0] sx, rd_val, rs_val, rt_val;
  logic [31:0] alu_a, alu_b, alu_y, wb_d, pc_d;
  logic        eq, lt, is_branch, is_rtype, writes_rd;

  assign op = ir_q[OP_MSB:OP_LSB];
  assign rd = ir_q[RD_MSB:RD_LSB];
  assign rs = ir_q[RS_MSB:RS_LSB];
  assign rt = ir_q[RT_MSB:RT_LSB];
  assign sx = sext16(ir_q[IMM_MSB:0]);

  assign rd_val = (rd == 4'd0) ? 32'h0 : regs_q[rd];
  assign rs_val = (rs == 4'd0) ? 32'h0 : regs_q[rs];
  assign rt_val = (rt == 4'd0) ? 32'h0 : regs_q[rt];

  assign is_branch = (op == OP_BEQ) || (op == OP_BNE);
  assign is_rtype  = (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_MUL});

  // Branches compare rd against rs; everything else uses rs with rt or the immediate
  assign alu_a = is_branch ? rd_val : rs_val;
  assign alu_b = is_branch ? rs_val : (is_rtype ? rt_val : sx);

  cpu_core_alu u_alu (
    .op_i    (op),
    .a_i     (alu_a),
    .b_i     (alu_b),
    .result_o(alu_y),
    .eq_o    (eq),
    .lt_o    (lt)
  );

  assign wb_d = (op == OP_SLT) ? {31'b0, lt} : alu_y;

  always_comb begin
    writes_rd = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI, OP_LUI, OP_SLT};
`ifdef CPU_MUL_EN
    if (op == OP_MUL) writes_rd = 1'b1;
`endif
  end

  always_comb begin
    pc_d = pc_q;
    if (op == OP_JMP)
      pc_d = {16'h0000, ir_q[IMM_MSB:0]};
    else if ((op == OP_BEQ && eq) || (op == OP_BNE && !eq))
      pc_d = pc_q + sx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      rw_q    <= 1'b1;
      addr_q  <= RESET_PC;
      dout_q  <= '0;
      halted  <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          ir_q    <= data_from_mem;
          pc_q    <= pc_q + 32'd1;
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          case (op)
            OP_LOAD: begin
              addr_q  <= alu_y;
              state_q <= ST_MEM;
            end
            OP_STORE: begin
              addr_q  <= alu_y;
              dout_q  <= rd_val;
              rw_q    <= 1'b0;
              state_q <= ST_MEM;
            end
            OP_HALT: begin
              halted  <= 1'b1;
              state_q <= ST_HALT;
            end
            default: begin
              if (writes_rd && rd != 4'd0) regs_q[rd] <= wb_d;
              pc_q    <= pc_d;
              addr_q  <= pc_d;
              state_q <= ST_FETCH;
            end
          endcase
        end
        ST_MEM: begin
          if (op == OP_LOAD) begin
            if (rd != 4'd0) regs_q[rd] <= data_from_mem;
            addr_q  <= pc_q;
            state_q <= ST_FETCH;
          end else begin
            // Close the write strobe but keep address/data for one more clock
            rw_q    <= 1'b1;
            state_q <= ST_WREL;
          end
        end
        ST_WREL: begin
          addr_q  <= pc_q;
          state_q <= ST_FETCH;
        end
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_FETCH;
      endcase
    end
  end

  assign rw          = rw_q;
  assign address_bus = addr_q;
  assign data_to_mem = dout_q;

endmodule

// File: tb/tb_cpu_core.sv
// Self-checking bench for cpu_core: runs a small program from ROM and compares the
// cycle-by-cycle bus trace against a scoreboard, then checks registers, RAM and HALT.
module tb_cpu_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        rw;
  logic [31:0] address_bus, data_from_mem, data_to_mem;

  always #5 clk = ~clk;

  logic [31:0] rom [0:131071];
  logic [31:0] ram [0:1023];

  assign data_from_mem = (address_bus < 32'h20000) ? rom[address_bus[16:0]] : ram[address_bus[9:0]];

  always @(posedge clk)
    if (!reset && !rw && address_bus >= 32'h20000) ram[address_bus[9:0]] <= data_to_mem;

  cpu_core dut (
    .clk          (clk),
    .reset        (reset),
    .rw           (rw),
    .address_bus  (address_bus),
    .data_from_mem(data_from_mem),
    .data_to_mem  (data_to_mem)
  );

`ifdef CPU_MUL_EN
  localparam logic [31:0] EXP_R8 = 32'hFFFF_FFF1;
`else
  localparam logic [31:0] EXP_R8 = 32'h0000_0000;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    logic        rw;
    logic        chk_d;
    logic [31:0] d;
  } bus_t;
  bus_t exp_q[$];

  task automatic push(input logic [31:0] a, input logic r, input logic c, input logic [31:0] d);
    bus_t e;
    e.addr = a; e.rw = r; e.chk_d = c; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic exp_two(input logic [31:0] a);
    push(a, 1'b1, 1'b0, 32'h0);
    push(a, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic exp_store(input logic [31:0] a, input logic [31:0] ea, input logic [31:0] d);
    exp_two(a);
    push(ea, 1'b0, 1'b1, d);
    push(ea, 1'b1, 1'b1, d);
  endtask

  task automatic exp_load(input logic [31:0] a, input logic [31:0] ea);
    exp_two(a);
    push(ea, 1'b1, 1'b0, 32'h0);
  endtask

  // Compares the current bus sample with the head of the queue, then advances one clock
  task automatic drain_trace(input string tag);
    bus_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (address_bus !== e.addr || rw !== e.rw || dut.halted !== 1'b0 ||
          (e.chk_d && data_to_mem !== e.d)) begin
        bad++;
        $display("FAIL %s bus: got addr=%h rw=%b dout=%h halted=%b want addr=%h rw=%b dout=%h halted=0",
                 tag, address_bus, rw, data_to_mem, dut.halted, e.addr, e.rw, e.d);
      end
      if (rw === 1'b0) $display("write addr=%h data=%h", address_bus, data_to_mem);
      @(posedge clk); #1;
    end
  endtask

  task automatic load_rom();
    for (int i = 0; i < 131072; i++) rom[i] = 32'h0;
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    rom[0]  = 32'h6100_0005; // ADDI r1,r0,5
    rom[1]  = 32'h6200_FFFD; // ADDI r2,r0,-3
    rom[2]  = 32'h1312_0000; // ADD  r3,r1,r2
    rom[3]  = 32'h2412_0000; // SUB  r4,r1,r2
    rom[4]  = 32'h7600_0002; // LUI  r6,2
    rom[5]  = 32'h9360_0000; // STORE r3,0(r6)
    rom[6]  = 32'h8560_0000; // LOAD r5,0(r6)
    rom[7]  = 32'hA530_0001; // BEQ r5,r3,+1
    rom[8]  = 32'h6700_0001; // ADDI r7,r0,1 (skipped)
    rom[9]  = 32'hE812_0000; // MUL r8,r1,r2
    rom[10] = 32'h9860_0001; // STORE r8,1(r6)
    rom[11] = 32'hB120_0001; // BNE r1,r2,+1
    rom[12] = 32'h6900_0007; // ADDI r9,r0,7 (skipped)
    rom[13] = 32'hDA21_0000; // SLT r10,r2,r1
    rom[14] = 32'hDB12_0000; // SLT r11,r1,r2
    rom[15] = 32'h3C12_0000; // AND r12
    rom[16] = 32'h4D12_0000; // OR  r13
    rom[17] = 32'h5E12_0000; // XOR r14
    rom[18] = 32'h6010_0000; // ADDI r0,r1,0 (discarded)
    rom[19] = 32'hC000_0015; // JMP 21
    rom[20] = 32'h6F00_0001; // ADDI r15,r0,1 (skipped)
    rom[21] = 32'h0000_0000; // NOP
    rom[22] = 32'hF000_0000; // HALT
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (address_bus !== 32'h0 || rw !== 1'b1 || dut.halted !== 1'b0 || data_to_mem !== 32'h0) begin
      bad++;
      $display("FAIL reset: got addr=%h rw=%b halted=%b dout=%h want addr=0 rw=1 halted=0 dout=0",
               address_bus, rw, dut.halted, data_to_mem);
    end
    reset = 1'b0;
  endtask

  task automatic test_program();
    for (int a = 0; a <= 4; a++) exp_two(32'(a));
    exp_store(32'd5, 32'h20000, 32'd2);
    exp_load(32'd6, 32'h20000);
    exp_two(32'd7);
    exp_two(32'd9);
    exp_store(32'd10, 32'h20001, EXP_R8);
    exp_two(32'd11);
    for (int a = 13; a <= 19; a++) exp_two(32'(a));
    exp_two(32'd21);
    exp_two(32'd22);
    drain_trace("program");
  endtask

  task automatic test_halt();
    total++;
    if (dut.halted !== 1'b1 || address_bus !== 32'd22 || rw !== 1'b1) begin
      bad++;
      $display("FAIL halt_entry: got halted=%b addr=%h rw=%b want halted=1 addr=16 rw=1",
               dut.halted, address_bus, rw);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (dut.halted !== 1'b1 || address_bus !== 32'd22 || rw !== 1'b1 || data_to_mem !== EXP_R8) begin
      bad++;
      $display("FAIL halt_frozen: got halted=%b addr=%h rw=%b dout=%h want halted=1 addr=16 rw=1 dout=%h",
               dut.halted, address_bus, rw, data_to_mem, EXP_R8);
    end
  endtask

  task automatic test_results();
    logic [31:0] exp_r [16];
    exp_r = '{32'h0, 32'd5, 32'hFFFF_FFFD, 32'd2, 32'd8, 32'd2, 32'h0002_0000, 32'h0,
              EXP_R8, 32'h0, 32'd1, 32'd0, 32'd5, 32'hFFFF_FFFD, 32'hFFFF_FFF8, 32'h0};
    for (int i = 0; i < 16; i++) begin
      total++;
      if (dut.regs_q[i] !== exp_r[i]) begin
        bad++;
        $display("FAIL reg_r%0d: got %h want %h", i, dut.regs_q[i], exp_r[i]);
      end
    end
    total++;
    if (ram[0] !== 32'd2) begin
      bad++;
      $display("FAIL ram0: got %h want %h", ram[0], 32'd2);
    end
    total++;
    if (ram[1] !== EXP_R8) begin
      bad++;
      $display("FAIL ram1: got %h want %h", ram[1], EXP_R8);
    end
  endtask

  task automatic test_reset_pulse();
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if (address_bus !== 32'h0 || rw !== 1'b1 || dut.halted !== 1'b0 || dut.regs_q[3] !== 32'h0) begin
      bad++;
      $display("FAIL reset_pulse: got addr=%h rw=%b halted=%b r3=%h want addr=0 rw=1 halted=0 r3=0",
               address_bus, rw, dut.halted, dut.regs_q[3]);
    end
    reset = 1'b0;
    exp_two(32'd0);
    exp_two(32'd1);
    push(32'd2, 1'b1, 1'b0, 32'h0);
    drain_trace("refetch");
    total++;
    if (dut.regs_q[1] !== 32'd5) begin
      bad++;
      $display("FAIL refetch_r1: got %h want %h", dut.regs_q[1], 32'd5);
    end
  endtask

  initial begin
    reset = 1'b1;
    load_rom();
    test_reset();
    test_program();
    test_halt();
    test_results();
    test_reset_pulse();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
